// File: rtl/cachemem_pkg.sv
// Shared types and width helpers for the multi-way cache data store.
// Optional write-first forwarding is enabled with CACHEMEM_BYPASS_EN.
package cachemem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_st_t;

  function automatic int aw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int ww_f(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int ow_f(input int lw);
    return $clog2(lw);
  endfunction

endpackage

// File: rtl/cachemem_bank.sv
// One way of the data store: byte-lane RAM, synchronous read-first port.
// The array has no reset; q only updates when re is high.
module cachemem_bank #(
  parameter int DW    = 64,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic            clk,
  input  logic            re,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/cachemem_ways.sv
// Set-associative data store: way banks, line-fill FSM, write arbitration.
// Define CACHEMEM_BYPASS_EN for write-first read forwarding.
module cachemem_ways
  import cachemem_pkg::*;
#(
  parameter  int DATAWIDTH   = 64,
  parameter  int CACHE_DEPTH = 2048,
  parameter  int WAYS        = 2,
  parameter  int LINE_WORDS  = 4,
  localparam int CSWIDTH     = DATAWIDTH/8,
  localparam int AW          = aw_f(CACHE_DEPTH),
  localparam int WW          = ww_f(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cwait,
  input  logic [AW-1:0]        raddr,
  input  logic [WW-1:0]        rway,
  output logic [DATAWIDTH-1:0] dato,
  input  logic [AW-1:0]        waddr,
  input  logic [WW-1:0]        wway,
  input  logic [DATAWIDTH-1:0] di,
  input  logic                 we,
  input  logic [CSWIDTH-1:0]   bsel,
  output logic                 wbusy,
  input  logic                 fill_start,
  input  logic [AW-1:0]        fill_addr,
  input  logic [WW-1:0]        fill_way,
  input  logic                 fill_valid,
  input  logic [DATAWIDTH-1:0] fill_data,
  output logic                 fill_ready,
  output logic                 fill_done
);

  localparam int OW = ow_f(LINE_WORDS);
  localparam int CW = (OW > 0) ? OW : 1;

  fill_st_t       st;
  logic [AW-1:0]  base;
  logic [WW-1:0]  fway;
  logic [CW-1:0]  cnt;
  logic           last;

  logic                 cpu_wr, fill_wr, wr, hit;
  logic [AW-1:0]        wa;
  logic [WW-1:0]        wsel;
  logic [CSWIDTH-1:0]   wbe;
  logic [DATAWIDTH-1:0] wd, wmask;

  logic [DATAWIDTH-1:0] bq [WAYS];
  logic [DATAWIDTH-1:0] rd, bmask, bdata;
  logic [WW-1:0]        rway_q;
  logic                 dv;

  // Fill beats own the write port; CPU writes only land while idle.
  always_comb begin
    cpu_wr  = (st == IDLE) && we;
    fill_wr = (st == FILL) && fill_valid;
    wr      = cpu_wr || fill_wr;
    wa      = fill_wr ? base + AW'(cnt) : waddr;
    wsel    = fill_wr ? fway : wway;
    wbe     = fill_wr ? '1 : bsel;
    wd      = fill_wr ? fill_data : di;
    last    = (cnt == CW'(LINE_WORDS-1));
    wmask   = '0;
    for (int i = 0; i < CSWIDTH; i++) begin
      wmask[i*8 +: 8] = {8{wbe[i]}};
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cachemem_bank #(
      .DW   (DATAWIDTH),
      .DEPTH(CACHE_DEPTH),
      .AW   (AW)
    ) u_bank (
      .clk  (clk),
      .re   (!cwait),
      .we   (wr && (wsel == WW'(g))),
      .be   (wbe),
      .waddr(wa),
      .wdata(wd),
      .raddr(raddr),
      .q    (bq[g])
    );
  end

  always_comb begin
    hit = 1'b0;
`ifdef CACHEMEM_BYPASS_EN
    hit = wr && (wsel == rway) && (wa == raddr) && (int'(rway) < WAYS);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv     <= 1'b0;
      rway_q <= '0;
      bmask  <= '0;
      bdata  <= '0;
    end else if (!cwait) begin
      dv     <= 1'b1;
      rway_q <= rway;
      bmask  <= hit ? wmask : '0;
      bdata  <= wd;
    end
  end

  always_comb begin
    rd = '0;
    for (int g = 0; g < WAYS; g++) begin
      if (rway_q == WW'(g)) rd = bq[g];
    end
    dato = dv ? ((rd & ~bmask) | (bdata & bmask)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      base       <= '0;
      fway       <= '0;
      cnt        <= '0;
      wbusy      <= 1'b0;
      fill_ready <= 1'b0;
      fill_done  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (fill_start) begin
            st         <= FILL;
            base       <= fill_addr & ~AW'(LINE_WORDS-1);
            fway       <= fill_way;
            cnt        <= '0;
            wbusy      <= 1'b1;
            fill_ready <= 1'b1;
          end
        end
        FILL: begin
          if (fill_valid) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              st         <= DONE;
              fill_ready <= 1'b0;
              fill_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          st        <= IDLE;
          fill_done <= 1'b0;
          wbusy     <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cachemem_ways.sv
// Scoreboard bench for cachemem_ways: directed cases plus random traffic.
module tb_cachemem_ways;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cwait = 1'b0;
  logic [10:0] raddr = '0;
  logic [0:0]  rway = '0;
  logic [63:0] dato;
  logic [10:0] waddr = '0;
  logic [0:0]  wway = '0;
  logic [63:0] di = '0;
  logic        we = 1'b0;
  logic [7:0]  bsel = '0;
  logic        wbusy;
  logic        fill_start = 1'b0;
  logic [10:0] fill_addr = '0;
  logic [0:0]  fill_way = '0;
  logic        fill_valid = 1'b0;
  logic [63:0] fill_data = '0;
  logic        fill_ready;
  logic        fill_done;

  cachemem_ways dut (
    .clk(clk), .rst_n(rst_n), .cwait(cwait),
    .raddr(raddr), .rway(rway), .dato(dato),
    .waddr(waddr), .wway(wway), .di(di),
    .we(we), .bsel(bsel), .wbusy(wbusy),
    .fill_start(fill_start), .fill_addr(fill_addr),
    .fill_way(fill_way), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_ready(fill_ready),
    .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    bit          dk;
    bit          busy;
    bit          rdy;
    bit          done;
  } exp_t;

  exp_t        q[$];
  int          nchk = 0;
  int          nerr = 0;
  int          done_cnt = 0;

  logic [63:0] mem [2][64];
  bit          kn  [2][64];
  logic [63:0] prev = '0;
  bit          prevk = 1'b1;
  int          phase = 0;
  int          fbase = 0;
  int          fw = 0;
  int          beats = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (fill_done) done_cnt++;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.dk) chk("dato", dato, e.d);
      chk("wbusy", 64'(wbusy), 64'(e.busy));
      chk("fill_ready", 64'(fill_ready), 64'(e.rdy));
      chk("fill_done", 64'(fill_done), 64'(e.done));
    end
  end

  // Predict the outcome of the coming edge from the current inputs.
  task automatic step();
    exp_t e;
    int   ra, rw, wa, ww, fa;
    bit   cw, fwr;
    ra  = int'(raddr);
    rw  = int'(rway);
    wa  = int'(waddr);
    ww  = int'(wway);
    fa  = fbase + beats;
    cw  = (phase == 0) && we;
    fwr = (phase == 1) && fill_valid;
    if (cwait) begin
      e.d  = prev;
      e.dk = prevk;
    end else begin
      e.d  = mem[rw][ra];
      e.dk = kn[rw][ra];
`ifdef CACHEMEM_BYPASS_EN
      if (cw && ww == rw && wa == ra)
        for (int i = 0; i < 8; i++)
          if (bsel[i]) e.d[i*8 +: 8] = di[i*8 +: 8];
      if (fwr && fw == rw && fa == ra) begin
        e.d  = fill_data;
        e.dk = 1'b1;
      end
`endif
    end
    prev  = e.d;
    prevk = e.dk;
    if (cw) begin
      for (int i = 0; i < 8; i++)
        if (bsel[i]) mem[ww][wa][i*8 +: 8] = di[i*8 +: 8];
      kn[ww][wa] = kn[ww][wa] || (bsel == 8'hFF);
    end
    if (fwr) begin
      mem[fw][fa] = fill_data;
      kn[fw][fa]  = 1'b1;
    end
    if (phase == 0) begin
      if (fill_start) begin
        fbase = int'(fill_addr) & ~3;
        fw    = int'(fill_way);
        beats = 0;
        phase = 1;
      end
    end else if (phase == 1) begin
      if (fill_valid) begin
        if (beats == 3) phase = 2;
        else beats++;
      end
    end else begin
      phase = 0;
    end
    e.busy = (phase != 0);
    e.rdy  = (phase == 1);
    e.done = (phase == 2);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic nop();
    cwait = 0; we = 0; fill_start = 0; fill_valid = 0; bsel = 0;
  endtask

  task automatic wr(input int w, input int a, input logic [63:0] d,
                    input logic [7:0] b);
    nop();
    we = 1; wway = 1'(w); waddr = 11'(a); di = d; bsel = b;
    step();
  endtask

  task automatic rd(input int w, input int a);
    nop();
    rway = 1'(w); raddr = 11'(a);
    step();
  endtask

  task automatic beat(input logic [63:0] d);
    nop();
    fill_valid = 1; fill_data = d;
    step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    chk("rst_dato", dato, 64'h0);
    chk("rst_wbusy", 64'(wbusy), 64'h0);
    chk("rst_fill_ready", 64'(fill_ready), 64'h0);
    chk("rst_fill_done", 64'(fill_done), 64'h0);
    #1;
    rst_n = 1;
    phase = 0;
    prev  = '0;
    prevk = 1'b1;
  endtask

  initial begin
    int d0;
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 64; a++) kn[w][a] = 1'b0;
    @(negedge clk);
    chk("init_dato", dato, 64'h0);
    chk("init_wbusy", 64'(wbusy), 64'h0);
    @(negedge clk);
    rst_n = 1;

    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 64; a++)
        wr(w, a, {$urandom, $urandom}, 8'hFF);

    // Byte-lane merge on way 1; way 0 must stay intact.
    wr(1, 16, 64'h1122334455667788, 8'hFF);
    wr(1, 16, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd(1, 16);
    chk("byte_lane", dato, 64'h11223344AAAAAAAA);
    rd(0, 16);

    // Hold the output while the address moves.
    rd(1, 16);
    for (int i = 0; i < 3; i++) begin
      nop(); cwait = 1; raddr = 11'(i + 1); rway = 0;
      step();
      chk("cwait_hold", dato, 64'h11223344AAAAAAAA);
    end
    rd(0, 3);

    // Line fill with a gap and a dropped CPU write.
    d0 = done_cnt;
    nop(); fill_start = 1; fill_addr = 11'h13; fill_way = 0;
    step();
    beat(64'hA0);
    beat(64'hA1);
    nop(); we = 1; wway = 0; waddr = 11'h11; di = '1; bsel = 8'hFF;
    step();
    beat(64'hA2);
    beat(64'hA3);
    nop(); step();
    nop(); step();
    chk("fill_done_once", 64'(done_cnt - d0), 64'd1);
    rd(0, 17);
    chk("fill_word1", dato, 64'hA1);
    rd(0, 19);
    chk("fill_word3", dato, 64'hA3);

    // Reset in the middle of a fill.
    d0 = done_cnt;
    nop(); fill_start = 1; fill_addr = 11'h10; fill_way = 0;
    step();
    beat(64'hB0);
    beat(64'hB1);
    do_reset();
    nop(); step();
    nop(); step();
    chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
    rd(0, 17);
    chk("rst_beat1", dato, 64'hB1);
    rd(0, 18);
    chk("rst_keep2", dato, 64'hA2);

    // Same-cycle read and write of one lane.
    wr(1, 32, 64'h0102030405060708, 8'hFF);
    nop(); we = 1; wway = 1; waddr = 11'd32; di = 64'hFFFFFFFFFFFFFFEE;
    bsel = 8'h01; rway = 1; raddr = 11'd32;
    step();
`ifdef CACHEMEM_BYPASS_EN
    chk("rdw_same", dato, 64'h01020304050607EE);
`else
    chk("rdw_same", dato, 64'h0102030405060708);
`endif
    rd(1, 32);
    chk("rdw_next", dato, 64'h01020304050607EE);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cwait      = ($urandom_range(0, 3) == 0);
      raddr      = 11'($urandom_range(0, 63));
      rway       = 1'($urandom);
      we         = ($urandom_range(0, 9) < 4);
      waddr      = 11'($urandom_range(0, 63));
      wway       = 1'($urandom);
      di         = {$urandom, $urandom};
      bsel       = 8'($urandom);
      fill_start = ($urandom_range(0, 9) == 0);
      fill_addr  = 11'($urandom_range(0, 63));
      fill_way   = 1'($urandom);
      fill_valid = ($urandom_range(0, 9) < 7);
      fill_data  = {$urandom, $urandom};
      step();
    end

    nop();
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/cachemem_ways.md
# cachemem_ways

Set-associative cache data store: `WAYS` independent byte-lane-writable banks of `CACHE_DEPTH` words each, sharing one clock. It provides a registered read port with way select and a `cwait` hold, a byte-enabled CPU write port, and a line-fill engine that writes a `LINE_WORDS`-beat refill burst from the bus interface. It sits between the cache controller (tag/hit logic, refill sequencing) and the bus master, and replaces the single-way two-clock data array.

## Interface
Derived widths:
- `CSWIDTH` = `DATAWIDTH/8`
- `AW` = clog2(`CACHE_DEPTH`)
- `WW` = max(1, clog2(`WAYS`))

Parameters:
- `DATAWIDTH`, 64, word width; must be a multiple of 8.
- `CACHE_DEPTH`, 2048, words per way; must be a power of 2.
- `WAYS`, 2, number of ways (1..8).
- `LINE_WORDS`, 4, words per cache line; must be a power of 2 and ≤ `CACHE_DEPTH`.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cwait` in 1: hold read output.
- `raddr` in AW: read word address.
- `rway` in WW: read way.
- `dato` out DATAWIDTH: registered read data.
- `waddr` in AW: CPU write word address.
- `wway` in WW: CPU write way.
- `di` in DATAWIDTH: CPU write data.
- `we` in 1: CPU write enable.
- `bsel` in CSWIDTH: byte lane enables.
- `wbusy` out 1: fill in progress; CPU writes dropped.
- `fill_start` in 1: begin line refill.
- `fill_addr` in AW: any address within the target line.
- `fill_way` in WW: target way.
- `fill_valid` in 1: fill beat present.
- `fill_data` in DATAWIDTH: fill beat data.
- `fill_ready` out 1: fill engine accepts a beat.
- `fill_done` out 1: one-cycle pulse after the last beat.

## Operation
- **Reset values:** `dato`=0, `wbusy`=0, `fill_ready`=0, `fill_done`=0, FSM=IDLE, beat counter=0. RAM contents are not reset.
- **Read:** on each posedge with `cwait`=0, `dato` ← mem[`rway`][`raddr`]. With `cwait`=1, `dato` holds its value; writes proceed unaffected.
- **CPU write:** when `we`=1 and FSM=IDLE, write byte lanes `i` with `bsel[i]`=1 of mem[`wway`][`waddr`] from `di`. When FSM≠IDLE, the CPU write is dropped and nothing is written.
- **Fill FSM states:**
  - IDLE → FILL on `fill_start`. Latch base = `fill_addr` with its low clog2(`LINE_WORDS`) bits cleared, latch `fill_way`, and clear the counter.
  - FILL: `fill_ready`=`wbusy`=1. Each cycle with `fill_valid`=1, write the full word `fill_data` to mem[way][base+cnt] and increment cnt. On the beat with cnt=`LINE_WORDS`-1 → DONE.
  - DONE: `fill_done`=1, `wbusy`=1, `fill_ready`=0, lasting one cycle; then → IDLE.
- `fill_start` outside IDLE is ignored.
- `fill_valid` outside FILL is ignored.
- Address arithmetic is modulo `CACHE_DEPTH`. The base is line-aligned, so a burst never crosses a line boundary.
- Out-of-range `rway`/`wway`/`fill_way` (≥ `WAYS`) suppresses writes. Reads from an out-of-range way return 0.
- **Reset mid-fill:** the FSM returns to IDLE with no `fill_done` pulse. Beats already written remain in memory.
- A `fill_start` and `we` in the same IDLE cycle: the CPU write is performed, and the fill starts next cycle.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- `wbusy` rises the cycle after `fill_start` is accepted and falls the cycle after DONE.
- Fill throughput: 1 beat per cycle. Minimum fill takes `LINE_WORDS`+2 cycles from `fill_start` to IDLE.
- Read-during-write to the same way and address: see Configuration.

## Configuration
- `CACHEMEM_BYPASS_EN` defined: write-first forwarding. A read matching the active write (CPU or fill) in the same cycle returns the merged data.
  - CPU write: `bsel` lanes from `di`, other lanes from memory.
  - Fill write: the full `fill_data` word.
  - `cwait` still takes precedence.
- `CACHEMEM_BYPASS_EN` not defined: read-first. A same-cycle read returns the old contents, and the new data is visible from the next read.

## Structure
- Package `cachemem_pkg`:
  - fill FSM state enum (IDLE, FILL, DONE);
  - width helper functions (clog2-based `AW`, `WW`, line offset width).
- Sub-module `cachemem_bank`: one per way. A single-clock, byte-lane-enabled `CACHE_DEPTH`×`DATAWIDTH` RAM with a synchronous read and no reset on the array.
- The top level holds the FSM, write arbitration, way muxing and bypass logic.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → `dato`=0, `wbusy`=0, `fill_ready`=0, `fill_done`=0 immediately (asynchronous).
- **Byte-lane write:**
  - Write 0x1122334455667788 to way 1, addr 0x10, with `bsel`=0xFF.
  - Then write `di`=0xAAAA… with `bsel`=0x0F.
  - Read → `dato`=0x11223344AAAAAAAA one cycle later.
  - Way 0, addr 0x10 is unchanged.
- **cwait hold:** with `cwait`=1 for 3 cycles while `raddr` changes → `dato` stays constant. Drop `cwait` → new data after 1 cycle.
- **Line fill:**
  - `fill_start` with `fill_addr`=0x13, way 0; beats 0xA0..0xA3 with one `fill_valid` gap cycle.
  - Required: words land at 0x10..0x13, `fill_done` pulses exactly once, and `wbusy` spans FILL+DONE.
  - A CPU `we` to 0x11 during the fill is dropped.
- **Reset mid-fill:** after 2 beats, pulse `rst_n` → FSM in IDLE, no `fill_done`, 0x10..0x11 written, 0x12..0x13 unchanged.
- **Read-during-write:** same way and address, `bsel`=0x01.
  - With `CACHEMEM_BYPASS_EN`: merged new data.
  - Without it: old data, then new data on the next read.
